efuse_rd_ctrl: RTL and testbench
================================

Name: efuse_rd_ctrl

Overview:
Serial eFuse read sequencer that sits directly downstream of the divided-clock generator (clk_div_r) in the eFuse subsystem.
- Does not clock logic on the divided clock. It detects rising edges of clk_div in the clk domain and uses them as timing ticks.
- Drives the eFuse macro pins CSB, LOAD, STROBE and ADDR bit by bit.
- Collects the fuse array into a shadow register and signals completion with a valid/done handshake.

Parameters:
- ADDR_W, 5, eFuse bit-address width; array holds 2**ADDR_W bits.
- DATA_W, 32, shadow register width; must equal 2**ADDR_W.
- STROBE_TICKS, 2, length of the STROBE high pulse in ticks (1..15).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- clk_div  input  1  divided clock level from the upstream divider, generated in the clk domain.
- start  input  1  one-clk request to read the whole array.
- busy  output  1  high from the accepted start until done.
- done  output  1  one-clk pulse when the read completes.
- valid  output  1  data_out holds a complete read; sticky until next start or reset.
- data_out  output  DATA_W  shadow register; bit i holds fuse i.
- efuse_csb  output  1  macro chip select, active low.
- efuse_load  output  1  macro read-mode select.
- efuse_strobe  output  1  macro read strobe.
- efuse_addr  output  ADDR_W  macro bit address.
- efuse_dout  input  1  macro read data.

Behaviour:
- Reset values:
  - busy=0, done=0, valid=0, data_out=0.
  - efuse_csb=1, efuse_load=0, efuse_strobe=0, efuse_addr=0.
  - FSM=IDLE, internal clk_div_d=1.
- Tick generation:
  - clk_div_d is registered from clk_div every clk.
  - tick = clk_div & ~clk_div_d (combinational, one clk wide).
  - clk_div_d resets to 1, so no spurious tick occurs on reset release.
- FSM states: IDLE, SETUP, STROBE, HOLD, FIN. All transitions except those out of IDLE and FIN occur only on clk cycles where tick=1.
- IDLE:
  - start=1 → SETUP.
  - On the same clk: busy<=1, valid<=0, bit address counter <=0, csb<=0, load<=1.
- SETUP: on tick → STROBE, strobe<=1, strobe counter <=0.
- STROBE:
  - On each tick the strobe counter increments.
  - On the tick where counter == STROBE_TICKS-1: data_out[addr] <= efuse_dout, strobe<=0, → HOLD.
  - The strobe is therefore high for exactly STROBE_TICKS ticks.
- HOLD: on tick:
  - If addr == DATA_W-1 → FIN.
  - Otherwise addr <= addr+1 → SETUP.
  - Address never wraps during a read.
- FIN (one clk, no tick needed): csb<=1, load<=0, addr<=0, busy<=0, valid<=1, done<=1 → IDLE.
- done is a single-clk pulse; cleared to 0 on every other cycle.
- Per-bit time is (2+STROBE_TICKS) ticks.
  - Full read = DATA_W*(2+STROBE_TICKS) ticks plus ≤1 tick start alignment plus 1 clk for FIN.
- start while busy=1 is ignored, with no effect on the read in progress.
- start on the same clk as FIN is ignored. busy is still 1 on that clk.
- clk_div stuck (no ticks): FSM holds its state indefinitely. No timeout is provided.
- Reset asserted mid-read: all outputs return to reset values asynchronously, and the partial data_out is discarded.
- data_out bits not yet read during a read in progress keep their previous values. Consumers qualify data_out with valid only.
- efuse_addr, efuse_csb, efuse_load and efuse_strobe are registered outputs (glitch-free to the macro).

Decomposition:
- Package efuse_pkg:
  - FSM state enum (3-bit encoding).
  - EFUSE_ADDR_W=5 and EFUSE_BITS=32 constants, shared with the program controller.
- Sub-module efuse_tick_det: clk_div_d register plus rising-edge tick output.
- The rest is a single FSM module.

Test Plan:
- Defaults; clk_div toggling every clk (period 2 clk, tick every 2 clk); macro model returns 32'hA5C3_0F81 by address; start pulse → csb low and load high for the whole read; 32 strobe pulses, each 2 ticks (4 clk) high; done pulse within 256+3 clk of start; data_out=32'hA5C3_0F81; valid=1; busy=0.
- Check efuse_addr per bit: increments only in HOLD→SETUP; stable while strobe=1; 0..31 in order; returns to 0 after FIN.
- start re-pulsed at clk 40 and clk 120 during busy → no restart; same data and done timing as a single-start run.
- rst_n low at bit 10 mid-strobe → immediately csb=1, strobe=0, load=0, busy=0, valid=0, data_out=0; a subsequent start completes a normal full read.
- clk_div held low for 100 clk during STROBE → strobe stays 1 and state is unchanged; the read resumes correctly after toggling restarts.
- STROBE_TICKS=1 build; all-ones fuse model → strobe 1 tick wide; full read takes 96 ticks; data_out=32'hFFFF_FFFF.

Source files
------------

// File: rtl/efuse_pkg.sv
// Shared eFuse subsystem definitions: array geometry and the read-sequencer state encoding.
package efuse_pkg;

  localparam int EFUSE_ADDR_W = 5;
  localparam int EFUSE_BITS   = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_FIN    = 3'd4
  } efuse_state_e;

endpackage

// File: rtl/efuse_tick_det.sv
// Turns the divided-clock level into a one-clk tick on each of its rising edges.
module efuse_tick_det (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_div,
  output logic tick
);

  logic clk_div_d;

  // Reset to 1 so a high clk_div at reset release does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) clk_div_d <= 1'b1;
    else        clk_div_d <= clk_div;
  end

  assign tick = clk_div & ~clk_div_d;

endmodule

// File: rtl/efuse_rd_ctrl.sv
// Serial eFuse read sequencer: walks every fuse bit through SETUP/STROBE/HOLD on
// divided-clock ticks and gathers the results into a shadow register.
module efuse_rd_ctrl
  import efuse_pkg::*;
#(
  parameter int ADDR_W       = EFUSE_ADDR_W,
  parameter int DATA_W       = EFUSE_BITS,
  parameter int STROBE_TICKS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_div,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              efuse_csb,
  output logic              efuse_load,
  output logic              efuse_strobe,
  output logic [ADDR_W-1:0] efuse_addr,
  input  logic              efuse_dout
);

  localparam logic [3:0]        STROBE_LAST = 4'(STROBE_TICKS - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(DATA_W - 1);

  logic tick;

  efuse_state_e      state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              csb_q, csb_d;
  logic              load_q, load_d;
  logic              strobe_q, strobe_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        scnt_q, scnt_d;

  efuse_tick_det u_tick_det (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_div (clk_div),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
      csb_q    <= 1'b1;
      load_q   <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      scnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      csb_q    <= csb_d;
      load_q   <= load_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      scnt_q   <= scnt_d;
    end
  end

  // Only IDLE and FIN act without a tick; a stalled clk_div freezes the sequence.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    data_d   = data_q;
    csb_d    = csb_q;
    load_d   = load_q;
    strobe_d = strobe_q;
    addr_d   = addr_q;
    scnt_d   = scnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETUP;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          addr_d  = '0;
          csb_d   = 1'b0;
          load_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d  = ST_STROBE;
          strobe_d = 1'b1;
          scnt_d   = '0;
        end
      end
      ST_STROBE: begin
        if (tick) begin
          if (scnt_q == STROBE_LAST) begin
            data_d[addr_q] = efuse_dout;
            strobe_d       = 1'b0;
            state_d        = ST_HOLD;
          end else begin
            scnt_d = scnt_q + 4'd1;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          if (addr_q == ADDR_LAST) begin
            state_d = ST_FIN;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_SETUP;
          end
        end
      end
      ST_FIN: begin
        csb_d   = 1'b1;
        load_d  = 1'b0;
        addr_d  = '0;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign valid        = valid_q;
  assign data_out     = data_q;
  assign efuse_csb    = csb_q;
  assign efuse_load   = load_q;
  assign efuse_strobe = strobe_q;
  assign efuse_addr   = addr_q;

endmodule

// File: tb/tb_efuse_rd_ctrl.sv
// Directed bench for efuse_rd_ctrl: a 2-tick-strobe instance with a fixed fuse pattern
// and a 1-tick-strobe instance reading an all-ones array.
module tb_efuse_rd_ctrl;
  import efuse_pkg::*;

  logic clk = 1'b0;
  logic clk_div = 1'b0;
  logic rst_n, div_run, start, start1;

  logic        busy, done, valid, efuse_csb, efuse_load, efuse_strobe, efuse_dout;
  logic [31:0] data_out;
  logic [4:0]  efuse_addr;
  logic        busy1, done1, valid1, csb1, load1, strobe1;
  logic [31:0] data_out1;
  logic [4:0]  addr1;
  logic        dout1;

  logic [31:0] fuse = 32'hA5C3_0F81;

  int n_checks = 0;
  int n_fail   = 0;

  int pulses = 0, pulse_idx = 0, wcur = 0;
  int order_viol = 0, width_viol = 0, pin_viol = 0;
  bit width_en = 1'b1;
  logic       prev_strobe = 1'b0, prev_busy = 1'b0;
  logic [4:0] prev_addr = '0;
  int pulses1 = 0, w1_cur = 0, w1_last = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (div_run) clk_div = ~clk_div;
    else         clk_div = 1'b0;
  end

  assign efuse_dout = fuse[efuse_addr];
  assign dout1      = 1'b1;

  efuse_rd_ctrl #(.ADDR_W(5), .DATA_W(32), .STROBE_TICKS(2)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .start(start),
    .busy(busy), .done(done), .valid(valid), .data_out(data_out),
    .efuse_csb(efuse_csb), .efuse_load(efuse_load), .efuse_strobe(efuse_strobe),
    .efuse_addr(efuse_addr), .efuse_dout(efuse_dout)
  );

  efuse_rd_ctrl #(.ADDR_W(5), .DATA_W(32), .STROBE_TICKS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div), .start(start1),
    .busy(busy1), .done(done1), .valid(valid1), .data_out(data_out1),
    .efuse_csb(csb1), .efuse_load(load1), .efuse_strobe(strobe1),
    .efuse_addr(addr1), .efuse_dout(dout1)
  );

  // Protocol watcher for the main instance: pin levels, address order, strobe width.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_strobe = 1'b0; prev_busy = 1'b0; prev_addr = '0; wcur = 0;
    end else begin
      if (busy && !prev_busy) pulse_idx = 0;
      if (busy && (efuse_csb !== 1'b0 || efuse_load !== 1'b1)) pin_viol++;
      if (busy && efuse_addr !== prev_addr &&
          (efuse_strobe || prev_strobe || efuse_addr !== prev_addr + 5'd1)) order_viol++;
      if (efuse_strobe && !prev_strobe) begin
        if (int'(efuse_addr) != pulse_idx) order_viol++;
        pulse_idx++; pulses++; wcur = 1;
      end else if (efuse_strobe) begin
        wcur++;
      end else if (prev_strobe) begin
        if (width_en && wcur != 4) width_viol++;
        wcur = 0;
      end
      prev_strobe = efuse_strobe; prev_busy = busy; prev_addr = efuse_addr;
    end
  end

  always @(negedge clk) begin
    if (strobe1) w1_cur++;
    else if (w1_cur != 0) begin
      w1_last = w1_cur; w1_cur = 0; pulses1++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start lands on a clk where clk_div is low, so the first tick is exactly one clk later.
  task automatic applyStimulus(input bit sel);
    @(negedge clk);
    while (clk_div !== 1'b0) @(negedge clk);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; start1 = 1'b0;
  endtask

  task automatic waitDone(input bit sel, input int re_a, input int re_b,
                          input int budget, output int edges);
    edges = 0;
    while (edges < budget) begin
      @(negedge clk);
      edges++;
      start = 1'b0;
      if (sel ? done1 : done) break;
      if (edges == re_a || edges == re_b) start = 1'b1;
    end
  endtask

  task automatic checkRead(input string tag, input int lat, input int exp_lat);
    if (exp_lat > 0) checkOutput({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({tag, "_done"},  {31'b0, done},       32'd1);
    checkOutput({tag, "_data"},  data_out,            32'hA5C3_0F81);
    checkOutput({tag, "_valid"}, {31'b0, valid},      32'd1);
    checkOutput({tag, "_busy"},  {31'b0, busy},       32'd0);
    checkOutput({tag, "_csb"},   {31'b0, efuse_csb},  32'd1);
    checkOutput({tag, "_load"},  {31'b0, efuse_load}, 32'd0);
    checkOutput({tag, "_addr"},  {27'b0, efuse_addr}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_done_clear"}, {31'b0, done},  32'd0);
  endtask

  initial begin
    int lat, n;
    int b_pulses, b_order, b_width, b_pin;
    rst_n = 1'b0; div_run = 1'b1; start = 1'b0; start1 = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",   {31'b0, busy},         32'd0);
    checkOutput("rst_done",   {31'b0, done},         32'd0);
    checkOutput("rst_valid",  {31'b0, valid},        32'd0);
    checkOutput("rst_data",   data_out,              32'd0);
    checkOutput("rst_csb",    {31'b0, efuse_csb},    32'd1);
    checkOutput("rst_load",   {31'b0, efuse_load},   32'd0);
    checkOutput("rst_strobe", {31'b0, efuse_strobe}, 32'd0);
    checkOutput("rst_addr",   {27'b0, efuse_addr},   32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Plain full read; 128 ticks on odd edges puts done right after edge 256.
    b_pulses = pulses; b_order = order_viol; b_width = width_viol; b_pin = pin_viol;
    applyStimulus(1'b0);
    checkOutput("start_busy", {31'b0, busy}, 32'd1);
    waitDone(1'b0, 0, 0, 400, lat);
    checkRead("read1", lat, 256);
    checkOutput("read1_pulses", 32'(pulses - b_pulses),    32'd32);
    checkOutput("read1_order",  32'(order_viol - b_order), 32'd0);
    checkOutput("read1_width",  32'(width_viol - b_width), 32'd0);
    checkOutput("read1_pins",   32'(pin_viol - b_pin),     32'd0);

    // Start re-pulsed mid-read must not disturb the sequence or its timing.
    fuse = 32'hA5C3_0F81;
    b_pulses = pulses; b_order = order_viol;
    applyStimulus(1'b0);
    waitDone(1'b0, 40, 120, 400, lat);
    checkRead("restart", lat, 256);
    checkOutput("restart_pulses", 32'(pulses - b_pulses),    32'd32);
    checkOutput("restart_order",  32'(order_viol - b_order), 32'd0);

    // Reset in the middle of bit 10's strobe.
    applyStimulus(1'b0);
    n = 0;
    while (!(efuse_strobe === 1'b1 && efuse_addr === 5'd10) && n < 400) begin
      @(negedge clk); n++;
    end
    checkOutput("bit10_reached", {31'b0, efuse_strobe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_csb",    {31'b0, efuse_csb},    32'd1);
    checkOutput("mid_rst_strobe", {31'b0, efuse_strobe}, 32'd0);
    checkOutput("mid_rst_load",   {31'b0, efuse_load},   32'd0);
    checkOutput("mid_rst_busy",   {31'b0, busy},         32'd0);
    checkOutput("mid_rst_valid",  {31'b0, valid},        32'd0);
    checkOutput("mid_rst_data",   data_out,              32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    b_pulses = pulses; b_order = order_viol; b_width = width_viol;
    applyStimulus(1'b0);
    waitDone(1'b0, 0, 0, 400, lat);
    checkRead("post_rst", lat, 256);
    checkOutput("post_rst_pulses", 32'(pulses - b_pulses),    32'd32);
    checkOutput("post_rst_order",  32'(order_viol - b_order), 32'd0);
    checkOutput("post_rst_width",  32'(width_viol - b_width), 32'd0);

    // clk_div stalls low during bit 5's strobe; everything must freeze, then resume.
    width_en = 1'b0;
    b_pulses = pulses; b_order = order_viol;
    applyStimulus(1'b0);
    n = 0;
    while (!(efuse_strobe === 1'b1 && efuse_addr === 5'd5) && n < 400) begin
      @(negedge clk); n++;
    end
    div_run = 1'b0;
    repeat (100) @(negedge clk);
    checkOutput("stall_strobe", {31'b0, efuse_strobe}, 32'd1);
    checkOutput("stall_state",  32'(dut.state_q),      32'(ST_STROBE));
    checkOutput("stall_addr",   {27'b0, efuse_addr},   32'd5);
    checkOutput("stall_busy",   {31'b0, busy},         32'd1);
    div_run = 1'b1;
    waitDone(1'b0, 0, 0, 600, lat);
    checkRead("stall", 0, 0);
    checkOutput("stall_pulses", 32'(pulses - b_pulses),    32'd32);
    checkOutput("stall_order",  32'(order_viol - b_order), 32'd0);
    width_en = 1'b1;

    // Single-tick strobe on an all-ones array: 96 ticks, each strobe two clks wide.
    b_pulses = pulses1;
    applyStimulus(1'b1);
    waitDone(1'b1, 0, 0, 400, lat);
    checkOutput("st1_latency", 32'(lat),          32'd192);
    checkOutput("st1_done",    {31'b0, done1},    32'd1);
    checkOutput("st1_data",    data_out1,         32'hFFFF_FFFF);
    checkOutput("st1_valid",   {31'b0, valid1},   32'd1);
    checkOutput("st1_csb",     {31'b0, csb1},     32'd1);
    checkOutput("st1_pulses",  32'(pulses1 - b_pulses), 32'd32);
    checkOutput("st1_width",   32'(w1_last),      32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
